// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the simple dual-port byte-enable RAM.
// Holds the sweep/run state encoding and the byte-lane count derivation.
package sdp_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sdp_state_e;

  function automatic int calc_num_bytes(input int word_length, input int byte_width);
    return word_length / byte_width;
  endfunction

endpackage

// File: rtl/sdp_be_mem_array.sv
// Storage array with per-lane write enables and a registered read port.
// Reads return the pre-write contents on a same-address collision.
module sdp_be_mem_array
  import sdp_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int WORD_LENGTH   = 40,
  parameter int BYTE_WIDTH    = 8,
  localparam int NUM_BYTES    = calc_num_bytes(WORD_LENGTH, BYTE_WIDTH),
  localparam int DEPTH        = 2 ** ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [NUM_BYTES-1:0]     wr_be,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [WORD_LENGTH-1:0]   wr_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [WORD_LENGTH-1:0]   rd_data
);

  logic [WORD_LENGTH-1:0] mem_array [DEPTH];
  logic [WORD_LENGTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wr_en && wr_be[b]) begin
        mem_array[wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Output register only moves on an accepted read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_array[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/simple_dual_port_be_ram.sv
// Simple dual-port RAM with byte-lane writes, a post-reset clear sweep and optional output register.
// Define SDP_RDW_BYPASS_EN to return the newly written lanes on a same-address read/write.
module simple_dual_port_be_ram
  import sdp_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int WORD_LENGTH   = 40,
  parameter int BYTE_WIDTH    = 8,
  parameter int OUT_REG       = 0,
  localparam int NUM_BYTES    = calc_num_bytes(WORD_LENGTH, BYTE_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [NUM_BYTES-1:0]     wr_be,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [WORD_LENGTH-1:0]   write_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [WORD_LENGTH-1:0]   read_data,
  output logic                     rd_valid,
  output logic                     init_busy
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = {ADDRESS_WIDTH{1'b1}};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  sdp_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                     in_init;
  logic                     rd_accept;
  logic                     rd_v1_q;

  logic                     mem_wr_en;
  logic [NUM_BYTES-1:0]     mem_wr_be;
  logic [ADDRESS_WIDTH-1:0] mem_wr_addr;
  logic [WORD_LENGTH-1:0]   mem_wr_data;
  logic [WORD_LENGTH-1:0]   mem_rd_data;
  logic [WORD_LENGTH-1:0]   s1_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == ADDR_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_ONE;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  assign in_init   = (state_q == ST_INIT);
  assign init_busy = in_init;
  assign rd_accept = reset_n && !in_init && rd_en;

  // The sweep owns the write port during INIT; no write lands while reset is held.
  assign mem_wr_en   = reset_n && (in_init || wr_en);
  assign mem_wr_be   = in_init ? {NUM_BYTES{1'b1}} : wr_be;
  assign mem_wr_addr = in_init ? init_cnt_q : write_address;
  assign mem_wr_data = in_init ? '0 : write_data;

  sdp_be_mem_array #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .WORD_LENGTH  (WORD_LENGTH),
    .BYTE_WIDTH   (BYTE_WIDTH)
  ) u_mem (
    .clk    (clk),
    .srst   (!reset_n),
    .wr_en  (mem_wr_en),
    .wr_be  (mem_wr_be),
    .wr_addr(mem_wr_addr),
    .wr_data(mem_wr_data),
    .rd_en  (rd_accept),
    .rd_addr(read_address),
    .rd_data(mem_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_v1_q <= 1'b0;
    end else begin
      rd_v1_q <= rd_accept;
    end
  end

`ifdef SDP_RDW_BYPASS_EN
  logic                   byp_hit_q;
  logic [NUM_BYTES-1:0]   byp_be_q;
  logic [WORD_LENGTH-1:0] byp_data_q;

  // Capture the colliding write alongside the read so its lanes can override the stale array word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byp_hit_q  <= 1'b0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else if (rd_accept) begin
      byp_hit_q  <= wr_en && (write_address == read_address);
      byp_be_q   <= wr_be;
      byp_data_q <= write_data;
    end
  end

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byp_lane
    assign s1_data[gi*BYTE_WIDTH +: BYTE_WIDTH] = (byp_hit_q && byp_be_q[gi])
        ? byp_data_q[gi*BYTE_WIDTH +: BYTE_WIDTH]
        : mem_rd_data[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end
`else
  assign s1_data = mem_rd_data;
`endif

  if (OUT_REG != 0) begin : g_out_reg
    logic                   rd_v2_q;
    logic [WORD_LENGTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rd_v2_q   <= 1'b0;
        rd_data_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) begin
          rd_data_q <= s1_data;
        end
      end
    end

    assign read_data = rd_data_q;
    assign rd_valid  = rd_v2_q;
  end else begin : g_no_out_reg
    assign read_data = s1_data;
    assign rd_valid  = rd_v1_q;
  end

endmodule

// File: tb/tb_simple_dual_port_be_ram.sv
// Self-checking bench: two instances (OUT_REG=0 and OUT_REG=1) share stimulus and are
// compared every cycle against a behavioural memory model, plus directed vector tables.
module tb_simple_dual_port_be_ram;

  localparam int AW    = 9;
  localparam int WL    = 40;
  localparam int BW    = 8;
  localparam int NB    = WL / BW;
  localparam int DEPTH = 2 ** AW;
`ifdef SDP_RDW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [NB-1:0] wr_be;
  logic [AW-1:0] write_address;
  logic [WL-1:0] write_data;
  logic          rd_en;
  logic [AW-1:0] read_address;
  logic [WL-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  simple_dual_port_be_ram #(.ADDRESS_WIDTH(AW), .WORD_LENGTH(WL), .BYTE_WIDTH(BW), .OUT_REG(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_be(wr_be), .write_address(write_address),
    .write_data(write_data), .rd_en(rd_en), .read_address(read_address),
    .read_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(busy_a)
  );

  simple_dual_port_be_ram #(.ADDRESS_WIDTH(AW), .WORD_LENGTH(WL), .BYTE_WIDTH(BW), .OUT_REG(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_be(wr_be), .write_address(write_address),
    .write_data(write_data), .rd_en(rd_en), .read_address(read_address),
    .read_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(busy_b)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: memory contents, remaining sweep cycles, and expected outputs per instance.
  logic [WL-1:0] mdl_mem [DEPTH];
  int            busy_cnt = DEPTH;
  logic          exp_a_v = 1'b0, pend_b_v = 1'b0, exp_b_v = 1'b0;
  logic [WL-1:0] exp_a_d = '0, pend_b_d = '0, exp_b_d = '0;

  task automatic chk(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WL-1:0] lane_mask(input logic [NB-1:0] be);
    logic [WL-1:0] m = '0;
    for (int i = 0; i < NB; i++) if (be[i]) m = m | (WL'({BW{1'b1}}) << (i * BW));
    return m;
  endfunction

  function automatic logic [WL-1:0] merge_w(input logic [WL-1:0] old_w, input logic [WL-1:0] new_w,
                                            input logic [NB-1:0] be);
    logic [WL-1:0] m = lane_mask(be);
    return (old_w & ~m) | (new_w & m);
  endfunction

  // One clock: predict from current inputs, advance the model, then compare both instances.
  task automatic step();
    logic          acc;
    logic [WL-1:0] rv;
    acc = reset_n && (busy_cnt == 0) && rd_en;
    rv  = mdl_mem[read_address];
    if (BYP && acc && wr_en && (write_address == read_address)) rv = merge_w(rv, write_data, wr_be);
    @(posedge clk);
    if (!reset_n) begin
      busy_cnt = DEPTH;
      exp_a_v = 1'b0; exp_a_d = '0;
      pend_b_v = 1'b0; exp_b_v = 1'b0; exp_b_d = '0;
    end else begin
      if (busy_cnt == 0) begin
        if (wr_en) mdl_mem[write_address] = merge_w(mdl_mem[write_address], write_data, wr_be);
      end else begin
        busy_cnt--;
        if (busy_cnt == 0) for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      end
      exp_b_v = pend_b_v;
      if (pend_b_v) exp_b_d = pend_b_d;
      pend_b_v = acc;
      if (acc) pend_b_d = rv;
      exp_a_v = acc;
      if (acc) exp_a_d = rv;
    end
    #1;
    chk("init_busy_a", WL'(busy_a), WL'(busy_cnt != 0));
    chk("init_busy_b", WL'(busy_b), WL'(busy_cnt != 0));
    chk("rd_valid_a", WL'(rd_valid_a), WL'(exp_a_v));
    chk("rd_valid_b", WL'(rd_valid_b), WL'(exp_b_v));
    chk("read_data_a", rd_data_a, exp_a_d);
    chk("read_data_b", rd_data_b, exp_b_d);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_be = '0; write_address = '0; write_data = '0;
    rd_en = 1'b0; read_address = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WL-1:0] d, input logic [NB-1:0] be);
    idle_inputs();
    wr_en = 1'b1; write_address = a; write_data = d; wr_be = be;
    step();
    idle_inputs();
  endtask

  typedef struct {
    logic          we;
    logic [NB-1:0] be;
    logic [AW-1:0] wa;
    logic [WL-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [WL-1:0] ed;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int n;
    int stray;
    logic [WL-1:0] v1, v2, v3;

    vecs[0]  = '{1'b1, 5'b11111, 9'd5,  40'h12_3456_789A, 1'b0, 9'd0,   1'b0, 40'h0};
    vecs[1]  = '{1'b1, 5'b00001, 9'd5,  40'hFF_FFFF_FFFF, 1'b0, 9'd0,   1'b0, 40'h0};
    vecs[2]  = '{1'b0, 5'b00000, 9'd0,  40'h0,            1'b1, 9'd5,   1'b1, 40'h12_3456_78FF};
    vecs[3]  = '{1'b1, 5'b11111, 9'd7,  40'h11_1111_1111, 1'b0, 9'd0,   1'b0, 40'h0};
    vecs[4]  = '{1'b1, 5'b11111, 9'd7,  40'hAA_AAAA_AAAA, 1'b1, 9'd7,   1'b1,
                 BYP ? 40'hAA_AAAA_AAAA : 40'h11_1111_1111};
    vecs[5]  = '{1'b0, 5'b00000, 9'd0,  40'h0,            1'b1, 9'd7,   1'b1, 40'hAA_AAAA_AAAA};
    vecs[6]  = '{1'b1, 5'b00000, 9'd9,  40'hDE_ADBE_EF00, 1'b0, 9'd0,   1'b0, 40'h0};
    vecs[7]  = '{1'b0, 5'b00000, 9'd0,  40'h0,            1'b1, 9'd9,   1'b1, 40'h0};
    vecs[8]  = '{1'b1, 5'b11111, 9'd10, 40'h55_6677_8899, 1'b1, 9'd5,   1'b1, 40'h12_3456_78FF};
    vecs[9]  = '{1'b0, 5'b00000, 9'd0,  40'h0,            1'b1, 9'd10,  1'b1, 40'h55_6677_8899};
    vecs[10] = '{1'b1, 5'b10100, 9'd12, 40'h11_2233_4455, 1'b1, 9'd12,  1'b1,
                 BYP ? 40'h11_0033_0000 : 40'h0};
    vecs[11] = '{1'b0, 5'b00000, 9'd0,  40'h0,            1'b1, 9'd12,  1'b1, 40'h11_0033_0000};
    vecs[12] = '{1'b0, 5'b00000, 9'd0,  40'h0,            1'b1, 9'h1FF, 1'b1, 40'h0};

    // Reset, then measure the clear sweep length.
    idle_inputs();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    n = 0;
    while (busy_a && n < 2000) begin step(); n++; end
    chk("init_busy_cycles", WL'(n), WL'(DEPTH));
    $display("sweep: init_busy cycles=%0d", n);

    // Directed vectors: result of each row visible on the OUT_REG=0 instance one cycle later.
    for (int i = 0; i < 13; i++) begin
      wr_en = vecs[i].we; wr_be = vecs[i].be; write_address = vecs[i].wa; write_data = vecs[i].wd;
      rd_en = vecs[i].re; read_address = vecs[i].ra;
      step();
      chk($sformatf("vec%0d_valid", i), WL'(rd_valid_a), WL'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d_data", i), rd_data_a, vecs[i].ed);
      $display("vec %0d: we=%0b wa=%0d re=%0b ra=%0d -> valid=%0b data=%h", i, vecs[i].we,
               vecs[i].wa, vecs[i].re, vecs[i].ra, rd_valid_a, rd_data_a);
    end
    idle_inputs();
    step();

    // Back-to-back reads through the output register instance.
    v1 = 40'h01_0101_0101; v2 = 40'h02_0202_0202; v3 = 40'h03_0303_0303;
    do_write(9'd1, v1, 5'b11111);
    do_write(9'd2, v2, 5'b11111);
    do_write(9'd3, v3, 5'b11111);
    rd_en = 1'b1; read_address = 9'd1; step();
    chk("b2b_c1_valid_b", WL'(rd_valid_b), WL'(0));
    read_address = 9'd2; step();
    chk("b2b_c2_valid_b", WL'(rd_valid_b), WL'(1)); chk("b2b_c2_data_b", rd_data_b, v1);
    read_address = 9'd3; step();
    chk("b2b_c3_valid_b", WL'(rd_valid_b), WL'(1)); chk("b2b_c3_data_b", rd_data_b, v2);
    rd_en = 1'b0; step();
    chk("b2b_c4_valid_b", WL'(rd_valid_b), WL'(1)); chk("b2b_c4_data_b", rd_data_b, v3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_hold_valid_b", WL'(rd_valid_b), WL'(0)); chk("b2b_hold_data_b", rd_data_b, v3);
    end
    $display("b2b: reads 1,2,3 -> last data=%h", rd_data_b);

    // Reset mid-sweep restarts from address 0 and wipes an earlier RUN write.
    do_write(9'd3, 40'hC0_FFEE_0003, 5'b11111);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    rd_en = 1'b1; read_address = 9'd3;
    stray = 0;
    for (int i = 0; i < 100; i++) begin step(); if (rd_valid_a || rd_valid_b) stray++; end
    reset_n = 1'b0; step(); reset_n = 1'b1;
    if (rd_valid_a || rd_valid_b) stray++;
    n = 0;
    while (busy_a && n < 2000) begin step(); n++; if (rd_valid_a || rd_valid_b) stray++; end
    chk("restart_busy_cycles", WL'(n), WL'(DEPTH));
    chk("init_stray_valid", WL'(stray), WL'(0));
    idle_inputs();
    rd_en = 1'b1; read_address = 9'd3; step();
    chk("addr3_cleared_valid_a", WL'(rd_valid_a), WL'(1)); chk("addr3_cleared_a", rd_data_a, 40'h0);
    rd_en = 1'b0; step();
    chk("addr3_cleared_valid_b", WL'(rd_valid_b), WL'(1)); chk("addr3_cleared_b", rd_data_b, 40'h0);
    $display("restart: busy cycles=%0d stray valids=%0d addr3=%h", n, stray, rd_data_b);

    // Randomised traffic with frequent address collisions.
    for (int i = 0; i < 3000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_be = NB'($urandom);
      write_address = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      write_data = {8'($urandom), 32'($urandom)};
      rd_en = 1'($urandom_range(0, 1));
      read_address = ($urandom_range(0, 2) == 0) ? write_address : AW'($urandom_range(0, 15));
      step();
    end
    idle_inputs();
    step(); step();
    $display("random: 3000 cycles done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
